// File: rtl/output_denormalizer_pkg.sv
// complex_adaptive_kalman_params: fixed-point widths and the normalization stats record
package complex_adaptive_kalman_params;
    localparam int FXP_WIDTH = 16;
    localparam int FXP_FRAC  = 12;
    localparam int ACC_WIDTH = 40;
    localparam int SAT_MAX   = 2 ** (FXP_WIDTH - 1) - 1;
    // var is a reserved word, so the deviation estimate is called var_est
    typedef struct packed {
        logic signed [FXP_WIDTH-1:0] mean;
        logic [FXP_WIDTH-1:0]        var_est;
    } norm_stats_t;
endpackage

// File: rtl/output_denormalizer_if.sv
// output_denormalizer_if: stats, sample-in and sample-out handshakes plus status
interface output_denormalizer_if
    import complex_adaptive_kalman_params::*;
#(
    parameter int STATS_DEPTH = 8
);
    logic                          st_valid;
    logic                          st_ready;
    logic signed [FXP_WIDTH-1:0]   st_mean;
    logic [FXP_WIDTH-1:0]          st_var;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [FXP_WIDTH-1:0]   in_sample;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [FXP_WIDTH-1:0]   out_sample;
    logic [7:0]                    sat_count;
    logic [$clog2(STATS_DEPTH):0]  stats_level;
    modport slave (
        input  st_valid, st_mean, st_var, in_valid, in_sample, out_ready,
        output st_ready, in_ready, out_valid, out_sample, sat_count, stats_level
    );
    modport master (
        output st_valid, st_mean, st_var, in_valid, in_sample, out_ready,
        input  st_ready, in_ready, out_valid, out_sample, sat_count, stats_level
    );
endinterface

// File: rtl/output_denormalizer_fifo.sv
// norm_stats_fifo: synchronous FIFO of stats records with occupancy, full and empty
module norm_stats_fifo
    import complex_adaptive_kalman_params::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  norm_stats_t               wdata,
    output norm_stats_t               rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW = $clog2(DEPTH);
    norm_stats_t   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign full    = level == (AW + 1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp];
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            level <= level + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end
endmodule

// File: rtl/output_denormalizer.sv
// output_denormalizer: restores out = sample * (2*var) + mean using the stats record
// queued for each sample at normalization; two-stage stallable pipeline with saturation
module output_denormalizer
    import complex_adaptive_kalman_params::*;
#(
    parameter int STATS_DEPTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    output_denormalizer_if.slave bus
);
    localparam logic signed [ACC_WIDTH-1:0] HI = ACC_WIDTH'(SAT_MAX);
    norm_stats_t                 head;
    logic                        full, empty, adv, accept, sat;
    logic                        s1_valid, s1_bypass, s2_valid;
    logic signed [ACC_WIDTH-1:0] prod, s1_prod, sum;
    logic signed [FXP_WIDTH-1:0] s1_mean, s1_sample, res;
    norm_stats_fifo #(.DEPTH(STATS_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.st_valid),
        .pop   (accept),
        .wdata (norm_stats_t'{mean: bus.st_mean, var_est: bus.st_var}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (bus.stats_level)
    );
    assign adv          = !s2_valid || bus.out_ready;
    assign bus.st_ready = !full;
    assign bus.in_ready = adv && !empty;
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = s2_valid;
    always_comb begin
        prod = ACC_WIDTH'(bus.in_sample) * ACC_WIDTH'($signed({1'b0, head.var_est, 1'b0}));
        sum  = (s1_prod >>> FXP_FRAC) + ACC_WIDTH'(s1_mean);
        sat  = !s1_bypass && (sum > HI || sum < -HI);
        res  = s1_bypass ? s1_sample : FXP_WIDTH'(sum > HI ? HI : sum < -HI ? -HI : sum);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_bypass      <= 1'b0;
            s1_prod        <= '0;
            s1_mean        <= '0;
            s1_sample      <= '0;
            s2_valid       <= 1'b0;
            bus.out_sample <= '0;
            bus.sat_count  <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod   <= prod;
                s1_mean   <= head.mean;
                s1_sample <= bus.in_sample;
                s1_bypass <= head.var_est == '0;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_sample <= res;
                if (sat && bus.sat_count != 8'hFF) bus.sat_count <= bus.sat_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_output_denormalizer.sv
// tb_output_denormalizer: directed and random checks against an arithmetic reference model
module tb_output_denormalizer;
    typedef struct {
        int m;
        int v;
    } st_t;
    logic        clk = 0;
    logic        rst_n = 0;
    int          checks = 0, passes = 0, fails = 0;
    int          n_acc = 0, sat_model = 0;
    st_t         mq[$];
    logic [15:0] exp_q[$];
    logic [15:0] held;
    logic [15:0] smp[4];
    int          k;
    output_denormalizer_if #(.STATS_DEPTH(8)) bus ();
    output_denormalizer #(.STATS_DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // out = floor(s * 2v / 4096) + m, clamped to +-32767; v == 0 passes s through
    function automatic logic [15:0] ref_out(input int s, input int m, input int v, output bit sat);
        longint p, q, r;
        sat = 0;
        if (v == 0) return 16'(s);
        p = longint'(s) * 2 * v;
        q = p / 4096;
        if (p < 0 && p % 4096 != 0) q--;
        r = q + m;
        if (r > 32767) begin r = 32767; sat = 1; end
        else if (r < -32767) begin r = -32767; sat = 1; end
        return 16'(r);
    endfunction
    task automatic tick();
        bit  s;
        int  lvl;
        st_t st;
        #1;
        lvl = mq.size();
        chk("stats_level", 64'(bus.stats_level), 64'(lvl));
        chk("st_ready", 64'(bus.st_ready), 64'(lvl < 8));
        if (lvl == 0) chk("in_ready_empty", 64'(bus.in_ready), 64'(0));
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", 64'(bus.out_valid), 64'(0));
            else chk("out_sample", 64'($unsigned(bus.out_sample)), 64'(exp_q.pop_front()));
        end
        if (bus.in_valid && bus.in_ready && lvl > 0) begin
            st = mq.pop_front();
            exp_q.push_back(ref_out(int'(bus.in_sample), st.m, st.v, s));
            if (s && sat_model < 255) sat_model++;
            n_acc++;
        end
        if (bus.st_valid && lvl < 8) mq.push_back('{m: int'(bus.st_mean), v: int'(bus.st_var)});
        @(posedge clk);
        #1;
    endtask
    task automatic push_st(input logic [15:0] m, input logic [15:0] v);
        bus.st_valid = 1;
        bus.st_mean = m;
        bus.st_var = v;
        tick();
        bus.st_valid = 0;
    endtask
    initial begin
        bus.st_valid = 0; bus.st_mean = 0; bus.st_var = 0;
        bus.in_valid = 0; bus.in_sample = 0; bus.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_sample", 64'($unsigned(bus.out_sample)), 64'(0));
        chk("rst_sat_count", 64'(bus.sat_count), 64'(0));
        chk("rst_stats_level", 64'(bus.stats_level), 64'(0));
        chk("rst_st_ready", 64'(bus.st_ready), 64'(1));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        rst_n = 1;
        // unity scale with mean offset, and two-cycle latency
        push_st(16'h0100, 16'h0800);
        bus.in_valid = 1; bus.in_sample = 16'h0400;
        tick();
        bus.in_valid = 0;
        chk("lat_cycle1", 64'(bus.out_valid), 64'(0));
        tick();
        chk("lat_cycle2", 64'(bus.out_valid), 64'(1));
        chk("unity_value", 64'($unsigned(bus.out_sample)), 64'(16'h0500));
        tick();
        // zero variance bypasses the scale and the mean
        push_st(16'h0100, 16'h0000);
        bus.in_valid = 1; bus.in_sample = 16'h1234;
        tick();
        bus.in_valid = 0;
        tick();
        chk("bypass_value", 64'($unsigned(bus.out_sample)), 64'(16'h1234));
        tick();
        // scale 8.0 overflows both ways into the symmetric limits
        push_st(16'h0000, 16'h4000);
        push_st(16'h0000, 16'h4000);
        bus.in_valid = 1; bus.in_sample = 16'h2000;
        tick();
        bus.in_sample = 16'hE000;
        tick();
        bus.in_valid = 0;
        chk("sat_pos", 64'($unsigned(bus.out_sample)), 64'(16'h7FFF));
        tick();
        chk("sat_neg", 64'($unsigned(bus.out_sample)), 64'(16'h8001));
        tick();
        tick();
        chk("sat_count_two", 64'(bus.sat_count), 64'(2));
        // fill the stats queue, one extra push must be dropped
        bus.st_valid = 1;
        for (int i = 0; i < 9; i++) begin
            bus.st_mean = 16'($urandom_range(0, 16'h0FFF));
            bus.st_var = 16'($urandom_range(1, 16'h0FFF));
            tick();
        end
        bus.st_valid = 0;
        chk("full_level", 64'(bus.stats_level), 64'(8));
        chk("full_st_ready", 64'(bus.st_ready), 64'(0));
        bus.in_valid = 1; bus.in_sample = 16'($urandom);
        tick();
        bus.in_valid = 0;
        chk("pop_level", 64'(bus.stats_level), 64'(7));
        chk("pop_st_ready", 64'(bus.st_ready), 64'(1));
        repeat (3) tick();
        // stall: only two samples fit in flight
        for (int i = 0; i < 4; i++) smp[i] = 16'($urandom);
        bus.out_ready = 0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1; bus.in_sample = smp[k];
            n_acc = 0;
            tick();
            k += n_acc;
        end
        chk("stall_accepted", 64'(k), 64'(2));
        chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
        held = bus.out_sample;
        repeat (3) begin
            tick();
            chk("stall_hold", 64'($unsigned(bus.out_sample)), 64'(held));
        end
        bus.out_ready = 1;
        for (int i = 0; i < 10 && k < 4; i++) begin
            bus.in_sample = smp[k];
            n_acc = 0;
            tick();
            k += n_acc;
        end
        chk("stall_all_in", 64'(k), 64'(4));
        bus.in_valid = 0;
        repeat (4) tick();
        // drain remaining stats, then an empty queue must refuse samples
        bus.in_valid = 1;
        for (int i = 0; i < 10 && mq.size() > 0; i++) begin
            bus.in_sample = 16'($urandom);
            tick();
        end
        repeat (3) tick();
        chk("empty_in_ready", 64'(bus.in_ready), 64'(0));
        bus.in_valid = 0;
        repeat (3) tick();
        // reset with samples in flight and stats queued
        for (int i = 0; i < 5; i++) push_st(16'($urandom), 16'($urandom_range(1, 16'h0FFF)));
        bus.out_ready = 0;
        bus.in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.in_sample = 16'($urandom);
            tick();
        end
        bus.in_valid = 0;
        chk("pre_rst_level", 64'(bus.stats_level), 64'(3));
        chk("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
        rst_n = 0;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_level", 64'(bus.stats_level), 64'(0));
        chk("mid_rst_sat_count", 64'(bus.sat_count), 64'(0));
        mq.delete();
        exp_q.delete();
        sat_model = 0;
        bus.out_ready = 1;
        @(posedge clk);
        #1;
        rst_n = 1;
        repeat (4) begin
            tick();
            chk("post_rst_quiet", 64'(bus.out_valid), 64'(0));
        end
        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            bus.st_valid = 1'($urandom_range(0, 1));
            bus.st_mean = 16'($urandom);
            bus.st_var = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h0FFF) << $urandom_range(0, 4));
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_sample = 16'($urandom);
            bus.out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        bus.st_valid = 0; bus.in_valid = 0; bus.out_ready = 1;
        repeat (6) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        chk("rand_sat_count", 64'(bus.sat_count), 64'(sat_model));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/output_denormalizer.md
Name: output_denormalizer

Overview:
Reverses the adaptive input normalization at the output of the complex adaptive filter path. It re-applies the per-sample statistics that were used at normalization: out = sample * (2*var) + mean. The normalization stage pushes one stats record (mean, var) per accepted sample into a stats queue. The block pops one record per filtered sample, so each sample is restored with exactly the statistics it was normalized with. It sits between the filter core output and the system output port.

Parameters:
FXP_WIDTH, 16, sample/mean/var width (signed Q format; var unsigned)
FXP_FRAC, 12, fractional bits
ACC_WIDTH, 40, internal accumulator width; must be >= 2*FXP_WIDTH+2
STATS_DEPTH, 8, stats queue depth (power of 2, >= 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
st_valid  in  1  stats record valid
st_ready  out  1  stats queue not full
st_mean  in  FXP_WIDTH  signed running mean at normalization
st_var  in  FXP_WIDTH  unsigned deviation estimate at normalization
in_valid  in  1  filtered normalized sample valid
in_ready  out  1  sample accepted this cycle when in_valid & in_ready
in_sample  in  FXP_WIDTH  signed normalized sample
out_valid  out  1  restored sample valid
out_ready  in  1  downstream ready
out_sample  out  FXP_WIDTH  signed restored sample
sat_count  out  8  saturating count of output saturation events
stats_level  out  $clog2(STATS_DEPTH)+1  stats queue occupancy

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_sample=0, sat_count=0, stats_level=0, queue empty, both pipeline stages empty.
  - Therefore st_ready=1 and in_ready=0 out of reset.
- Reset asserted mid-operation discards all queued stats and in-flight samples immediately.
- Stats queue:
  - Push when st_valid & st_ready.
  - st_ready = !full, computed from registered occupancy only. A pop in the same cycle does not make room.
  - Pushes when full are ignored.
- Pipeline advance: adv = !s2_valid | out_ready.
- Sample accept: in_ready = adv & !empty, from registered occupancy. A push into an empty queue in the same cycle does not enable acceptance.
  - On accept, the queue head pops in the same cycle.
  - stats_level updates next cycle; it is unchanged on simultaneous push and pop.
- Stage 1 (on accept and adv):
  - scale = {1'b0, var, 1'b0}, i.e. 2*var, zero-extended and treated as signed.
  - prod = in_sample * scale, ACC_WIDTH signed.
  - Register prod, mean, and bypass = (var == 0).
  - If adv and no accept, s1_valid clears.
- Stage 2 (on adv with s1_valid):
  - Not bypass: sum = (prod >>> FXP_FRAC) + sign-extended mean. The shift is arithmetic, rounding toward negative infinity.
  - Saturate sum symmetrically to [-(2^(FXP_WIDTH-1)-1), 2^(FXP_WIDTH-1)-1].
  - Bypass: out_sample = the stage-1 sample unchanged, with mean not added.
  - out_valid set.
  - If adv and !s1_valid, out_valid clears.
- Stall: when out_valid & !out_ready, both stages hold and out_sample is stable. At most 2 samples are in flight.
- Latency: 2 cycles from sample accept to out_valid with no stall. Full throughput is 1 sample per cycle.
- sat_count increments by 1 per saturated output registered. It holds at 255.

Decomposition:
- Shared package (complex_adaptive_kalman_params) holds:
  - FXP_WIDTH, FXP_FRAC, ACC_WIDTH
  - SAT_MAX constant, equal to 2^(FXP_WIDTH-1)-1
  - norm_stats_t struct {signed mean; unsigned var}, also reused by input_normalizer to emit stats
- One sub-module: norm_stats_fifo, a synchronous FIFO of norm_stats_t with level, full and empty outputs.

Test Plan:
- Push stats mean=0x0100, var=0x0800 (scale 1.0); sample 0x0400 -> out_sample=0x0500, out_valid exactly 2 cycles after accept.
- Stats var=0x0000, mean=0x0100; sample 0x1234 -> out_sample=0x1234 (bypass, mean not added).
- Stats var=0x4000 (scale 8.0), mean=0; samples 0x2000 then 0xE000 -> outputs 0x7FFF then 0x8001; sat_count=2.
- Push 8 stats with no samples -> stats_level=8, st_ready=0, 9th push ignored. One sample accepted -> stats_level=7 next cycle, st_ready=1.
- Hold out_ready=0 with 4 samples offered -> only 2 accepted, in_ready=0, out_sample stable. Release -> all 4 emerge in order with correct values.
- Stats queue empty with in_valid=1 -> in_ready=0. Assert rst_n=0 with 2 samples in flight and 3 stats queued -> out_valid=0 and stats_level=0 immediately; no stale outputs after release.
